// File: rtl/l1_flatten_stream_pkg.sv
// Shared definitions for the layer-1 flatten stage: FSM states, frame geometry
// and the result-memory select value used by the convolution engine.
package l1_flatten_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int   N_WORDS = 1024;
  localparam int   AW      = 12;
  localparam int   DW      = 13;
  localparam logic L1_SEL  = 1'b1;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry skid FIFO; the head word is always visible on head while not empty.
module skid_fifo2 #(
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          full,
  output logic          empty,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [2];
  logic [DW-1:0] mem_d [2];
  logic          wr_q, wr_d;
  logic          rd_q, rd_d;
  logic [1:0]    count_q, count_d;

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      mem_d[wr_q] = push_data;
      wr_d        = ~wr_q;
    end
    if (pop) begin
      rd_d = ~rd_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/l1_flatten_stream.sv
// Streams the 32x32 layer-1 result memory out in raster order as valid/ready beats.
// Define FLAT_MAXTRACK_EN to add the running signed maximum / index outputs.
module l1_flatten_stream #(
  parameter int N_WORDS = l1_flatten_stream_pkg::N_WORDS,
  parameter int AW      = l1_flatten_stream_pkg::AW,
  parameter int DW      = l1_flatten_stream_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  output logic          csel,
  input  logic [DW-1:0] cdata_rd,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  output logic          m_last,
  input  logic          m_ready
`ifdef FLAT_MAXTRACK_EN
 ,output logic          max_valid,
  output logic [DW-1:0] max_data,
  output logic [9:0]    max_idx
`endif
);

  import l1_flatten_stream_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);

  state_t        state_q, state_d;
  logic          busy_q, busy_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] beat_q, beat_d;
  logic          pend_q;
  logic          issue, pop;
  logic          fifo_full, fifo_empty;
  logic [1:0]    fifo_count;
  logic [2:0]    credit_used;

  skid_fifo2 #(.DW(DW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (pend_q),
    .push_data (cdata_rd),
    .pop       (pop),
    .head      (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A beat leaving this cycle frees its slot, so sustained streaming needs no bubble.
  assign credit_used = {1'b0, fifo_count} + {2'b00, pend_q} - {2'b00, pop};
  assign issue       = (state_q == RUN) && !fifo_full && (credit_used < 3'd2);
  assign m_valid     = ~fifo_empty;
  assign pop         = m_valid & m_ready;
  assign m_last      = m_valid && (beat_q == LAST_ADDR);
  assign crd         = issue;
  assign caddr_rd    = rd_ptr_q;
  assign csel        = L1_SEL;
  assign busy        = busy_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    rd_ptr_d = rd_ptr_q;
    beat_d   = beat_q;
    unique case (state_q)
      IDLE: begin
        rd_ptr_d = '0;
        beat_d   = '0;
        if (ready) begin
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        if (issue) begin
          if (rd_ptr_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            rd_ptr_d = rd_ptr_q + 1'b1;
          end
        end
        if (pop) begin
          beat_d = beat_q + 1'b1;
        end
      end
      DRAIN: begin
        if (pop) begin
          beat_d = beat_q + 1'b1;
          if (m_last) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      rd_ptr_q <= '0;
      beat_q   <= '0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q   <= beat_d;
      pend_q   <= issue;
    end
  end

`ifdef FLAT_MAXTRACK_EN
  logic          max_valid_q, max_valid_d;
  logic [DW-1:0] max_data_q, max_data_d;
  logic [9:0]    max_idx_q, max_idx_d;

  // Strict greater-than keeps the first occurrence on ties.
  always_comb begin
    max_valid_d = (state_q == DRAIN) && pop && m_last;
    max_data_d  = max_data_q;
    max_idx_d   = max_idx_q;
    if (state_q == IDLE && ready) begin
      max_data_d = '0;
      max_idx_d  = '0;
    end else if (pop && (beat_q == '0 || $signed(m_data) > $signed(max_data_q))) begin
      max_data_d = m_data;
      max_idx_d  = beat_q[9:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_valid_q <= 1'b0;
      max_data_q  <= '0;
      max_idx_q   <= '0;
    end else begin
      max_valid_q <= max_valid_d;
      max_data_q  <= max_data_d;
      max_idx_q   <= max_idx_d;
    end
  end

  assign max_valid = max_valid_q;
  assign max_data  = max_data_q;
  assign max_idx   = max_idx_q;
`endif

endmodule

// File: tb/tb_l1_flatten_stream.sv
// Directed bench for l1_flatten_stream: full frames under several m_ready patterns,
// mid-frame reset, repeated ready, and (with FLAT_MAXTRACK_EN) max tracking.
module tb_l1_flatten_stream;

  localparam int N  = 1024;
  localparam int AW = 12;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          ready;
  logic          busy;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic          csel;
  logic [DW-1:0] cdata_rd;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
`ifdef FLAT_MAXTRACK_EN
  logic          max_valid;
  logic [DW-1:0] max_data;
  logic [9:0]    max_idx;
`endif

  int checks   = 0;
  int errors   = 0;
  int mem_mode = 0;

  l1_flatten_stream dut (
    .clk      (clk),
    .reset    (reset),
    .ready    (ready),
    .busy     (busy),
    .crd      (crd),
    .caddr_rd (caddr_rd),
    .csel     (csel),
    .cdata_rd (cdata_rd),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready)
`ifdef FLAT_MAXTRACK_EN
   ,.max_valid(max_valid),
    .max_data (max_data),
    .max_idx  (max_idx)
`endif
  );

  always #5 clk = ~clk;

  // Memory image: mode 0 is a ramp, mode 1 is all negative except two equal peaks.
  function automatic logic [DW-1:0] mem_word(input int i);
    logic [DW-1:0] w;
    w = i[DW-1:0];
    if (mem_mode == 0) return w;
    if (i == 700 || i == 900) return 13'h0FFF;
    return 13'h1000 | w;
  endfunction

  // Result memory responds one clock after the read strobe.
  always @(posedge clk) begin
    if (crd) cdata_rd <= mem_word(int'(caddr_rd));
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkResetValues();
    checkOutput("rst_busy",    32'(busy),     32'd0);
    checkOutput("rst_crd",     32'(crd),      32'd0);
    checkOutput("rst_caddr",   32'(caddr_rd), 32'd0);
    checkOutput("rst_csel",    32'(csel),     32'd1);
    checkOutput("rst_m_valid", 32'(m_valid),  32'd0);
    checkOutput("rst_m_data",  32'(m_data),   32'd0);
    checkOutput("rst_m_last",  32'(m_last),   32'd0);
`ifdef FLAT_MAXTRACK_EN
    checkOutput("rst_max_valid", 32'(max_valid), 32'd0);
    checkOutput("rst_max_data",  32'(max_data),  32'd0);
    checkOutput("rst_max_idx",   32'(max_idx),   32'd0);
`endif
  endtask

  // rmode: 0 = m_ready high, 1 = 1,0,0,1 pattern, 2 = held low for the first 52 cycles.
  task automatic applyStimulus(input int rmode, input int abort_beat, input bit reready);
    int beat, cyc, issues, busy_cyc, first_valid, max_out;
    bit done;
    logic [DW-1:0] exp_max;
    int exp_idx;
    beat = 0; cyc = 0; issues = 0; busy_cyc = 0; first_valid = -1; max_out = 0;
    done = 1'b0;
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    while (!done && cyc < 4000) begin
      case (rmode)
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        2:       m_ready = (cyc >= 52);
        default: m_ready = 1'b1;
      endcase
      if (reready) ready = (cyc >= 100 && cyc <= 110);
      #1;
      if (busy) busy_cyc++;
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (crd) begin
        checkOutput("caddr", 32'(caddr_rd), 32'(issues));
        issues++;
      end
      if (m_valid && m_ready) begin
        checkOutput("m_data", 32'(m_data), 32'(mem_word(beat)));
        checkOutput("m_last", 32'(m_last), 32'(beat == N - 1));
        beat++;
      end
      if (issues - beat > max_out) max_out = issues - beat;
      if (rmode == 2 && cyc == 51) begin
        checkOutput("stall_issues", 32'(issues), 32'd2);
        checkOutput("stall_valid",  32'(m_valid), 32'd1);
      end
`ifdef FLAT_MAXTRACK_EN
      if (cyc == 10) checkOutput("max_valid_mid", 32'(max_valid), 32'd0);
`endif
      if (abort_beat >= 0 && beat == abort_beat) begin
        reset = 1'b0;
        #1;
        checkResetValues();
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b0;
        return;
      end
      if (cyc > 0 && !busy) begin
        done = 1'b1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("frame_done",  32'(done),        32'd1);
    checkOutput("first_valid", 32'(first_valid), 32'd2);
    checkOutput("beats",       32'(beat),        32'(N));
    checkOutput("issues",      32'(issues),      32'(N));
    checkOutput("outstanding_le2", 32'(max_out <= 2), 32'd1);
    if (rmode == 0) checkOutput("busy_cycles", 32'(busy_cyc), 32'(N + 2));
`ifdef FLAT_MAXTRACK_EN
    exp_max = '0;
    exp_idx = 0;
    for (int i = 0; i < N; i++) begin
      if (i == 0 || $signed(mem_word(i)) > $signed(exp_max)) begin
        exp_max = mem_word(i);
        exp_idx = i;
      end
    end
    checkOutput("max_valid_pulse", 32'(max_valid), 32'd1);
    checkOutput("max_data",        32'(max_data),  32'(exp_max));
    checkOutput("max_idx",         32'(max_idx),   32'(exp_idx));
    @(negedge clk);
    #1;
    checkOutput("max_valid_drop", 32'(max_valid), 32'd0);
    checkOutput("max_data_hold",  32'(max_data),  32'(exp_max));
`else
    exp_max = '0;
    exp_idx = 0;
`endif
    m_ready = 1'b0;
    ready   = 1'b0;
  endtask

  initial begin
    reset   = 1'b0;
    ready   = 1'b0;
    m_ready = 1'b0;
    #12;
    checkResetValues();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] ramp frame, m_ready high");
    applyStimulus(0, -1, 1'b0);
    $display("[TB] ramp frame, m_ready 1,0,0,1");
    applyStimulus(1, -1, 1'b0);
    $display("[TB] ramp frame, initial stall");
    applyStimulus(2, -1, 1'b0);
    $display("[TB] reset at beat 300");
    applyStimulus(0, 300, 1'b0);
    $display("[TB] frame after reset");
    applyStimulus(0, -1, 1'b0);
    $display("[TB] ready re-asserted during frame");
    applyStimulus(0, -1, 1'b1);
    repeat (5) begin
      @(negedge clk);
      #1;
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_crd",  32'(crd),  32'd0);
    end
`ifdef FLAT_MAXTRACK_EN
    $display("[TB] max tracking frame");
    mem_mode = 1;
    applyStimulus(0, -1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l1_flatten_stream.md
# l1_flatten_stream

Downstream stage of the 5x5 convolution engine. Once the engine has filled the layer-1 (max-pooled, 32x32) result memory, this block reads all 1024 words through the engine's shared result-memory read port. It emits them in raster order as a valid/ready stream for the next network stage, with a 2-entry skid buffer absorbing backpressure.

## Interface
Parameters:
- N_WORDS, 1024: words streamed per frame (32x32 layer-1 map).
- AW, 12: result-memory address width.
- DW, 13: data width; signed two's-complement fixed point.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ready  in  1  frame-available request; sampled only in IDLE.
- busy  out  1  high from frame start until the last beat is accepted.
- crd  out  1  memory read strobe.
- caddr_rd  out  AW  read address, 0..N_WORDS-1.
- csel  out  1  memory select; constant 1 (layer-1 memory).
- cdata_rd  in  DW  read data; valid on the rising edge after the crd cycle.
- m_valid  out  1  output beat valid.
- m_data  out  DW  output word.
- m_last  out  1  high with the beat of word N_WORDS-1.
- m_ready  in  1  downstream accept.
- max_valid, max_data[DW], max_idx[10]  out  present only with FLAT_MAXTRACK_EN.

## Operation
- FSM: IDLE -> RUN (ready=1 sampled) -> DRAIN (last read issued) -> IDLE (last beat accepted).
- IDLE: busy=0, crd=0. The read pointer and beat counter are cleared.
- RUN: issue a read when fifo_count + inflight < 2. The read pointer increments on every issue. The issue for word N_WORDS-1 moves the FSM to DRAIN.
- In-flight read: cdata_rd is captured one cycle after issue and pushed into the 2-entry FIFO.
- The FIFO head drives m_data. m_valid = FIFO not empty. A beat transfers on m_valid & m_ready, and the beat counter increments.
- m_last is high when the beat counter equals N_WORDS-1.
- DRAIN: no reads are issued. On the transfer of the m_last beat, go to IDLE with busy=0 on the next cycle.
- Data passes unmodified; no arithmetic on the stream path.
- Simultaneous push and pop with a full FIFO is legal; the count is unchanged. Push is never attempted when full, because the credit rule guarantees it.
- m_ready low for any duration: reads stall after the FIFO and in-flight slots fill. No data is lost or duplicated.
- ready asserted again while busy is ignored. A new frame starts only from IDLE.

## Timing
- Reset values: busy=0, crd=0, caddr_rd=0, csel=1, m_valid=0, m_data=0, m_last=0, max_valid=0, max_data=0, max_idx=0.
- The FSM enters RUN the cycle after ready is sampled high; busy rises that cycle and the first crd is issued the same cycle.
- First m_valid appears 2 cycles after busy rises.
- With m_ready held high, one beat per cycle is sustained. The frame completes in N_WORDS+2 cycles from busy rising to busy falling.
- Reset asserted mid-frame: all state returns to reset values immediately. The partial frame is abandoned and not resumed.

## Configuration
- FLAT_MAXTRACK_EN defined:
  - A running signed maximum and its index (first occurrence wins ties) are updated on every accepted beat.
  - max_valid pulses for 1 cycle, coincident with busy falling. max_data and max_idx hold until the next frame starts, then clear.
- FLAT_MAXTRACK_EN undefined: the max_* ports and their logic are absent.

## Structure
- The shared package holds the FSM state enum (IDLE, RUN, DRAIN) and the constants N_WORDS, AW, DW and L1_SEL=1 used by the convolution engine.
- Sub-module skid_fifo2 (2-entry, DW wide; push/pop/full/empty/count) is instantiated once.

## Test plan
- Memory preloaded with word i = i; ready pulsed; m_ready=1 -> 1024 beats with data 0..1023; m_last only on 1023; busy high 1026 cycles.
- Same frame with m_ready toggling 1,0,0,1 repeating -> identical data sequence, no gaps or duplicates; at most 2 words outstanding beyond accepted beats.
- m_ready held 0 for 50 cycles after the first beat -> crd stops after 2 issues; streaming resumes correctly when m_ready rises.
- reset driven low at beat 300, then a new frame started -> all outputs at reset values; the new frame starts again at address 0.
- FLAT_MAXTRACK_EN: word 700 = 0x0FFF, word 900 = 0x0FFF, others negative -> max_data=0x0FFF, max_idx=700, max_valid pulses with busy falling.
- ready asserted again during a frame -> no effect; exactly one frame streamed.
